// File: rtl/accelerator_state_vector_update_pkg.sv
// Shared types, constants and saturation helper for the LSTM cell-state update datapath.
package accelerator_state_vector_update_pkg;

    localparam int MAX_DATA_SIZE = 64;
    localparam int SAT_WIDTH     = 2 * MAX_DATA_SIZE;

    typedef enum logic [1:0] {
        STARTER_STATE  = 2'd0,
        INPUT_STATE    = 2'd1,
        MULTIPLY_STATE = 2'd2,
        ADD_STATE      = 2'd3
    } state_t;

    typedef struct packed {
        logic f;
        logic i;
        logic a;
        logic s;
    } operand_flags_t;

    localparam logic [MAX_DATA_SIZE-1:0] ZERO_DATA = '0;
    localparam logic [MAX_DATA_SIZE-1:0] ONE_DATA  = {{(MAX_DATA_SIZE-1){1'b0}}, 1'b1};

    // Clamp a sign-extended value into a signed 'width'-bit range; the caller keeps the low 'width' bits.
    function automatic logic signed [MAX_DATA_SIZE-1:0] saturate(
        input logic signed [SAT_WIDTH-1:0] value,
        input int unsigned                 width
    );
        logic signed [SAT_WIDTH-1:0] one_v;
        logic signed [SAT_WIDTH-1:0] max_v;
        logic signed [SAT_WIDTH-1:0] min_v;
        one_v = {{(SAT_WIDTH-1){1'b0}}, 1'b1};
        max_v = (one_v << (width - 1)) - one_v;
        min_v = ~max_v;
        if (value > max_v) begin
            saturate = max_v[MAX_DATA_SIZE-1:0];
        end else if (value < min_v) begin
            saturate = min_v[MAX_DATA_SIZE-1:0];
        end else begin
            saturate = value[MAX_DATA_SIZE-1:0];
        end
    endfunction

endpackage

// File: rtl/accelerator_state_vector_update_if.sv
// Operand/result stream bundle between the gate producers and the state-update engine.
interface accelerator_state_vector_update_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 F_IN_ENABLE;
    logic                 I_IN_ENABLE;
    logic                 A_IN_ENABLE;
    logic                 S_IN_ENABLE;
    logic                 F_OUT_ENABLE;
    logic                 I_OUT_ENABLE;
    logic                 A_OUT_ENABLE;
    logic                 S_OUT_ENABLE_REQ;
    logic                 S_OUT_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_L_IN;
    logic [DATA_SIZE-1:0] F_IN;
    logic [DATA_SIZE-1:0] I_IN;
    logic [DATA_SIZE-1:0] A_IN;
    logic [DATA_SIZE-1:0] S_IN;
    logic [DATA_SIZE-1:0] S_OUT;

    modport master (
        output START, F_IN_ENABLE, I_IN_ENABLE, A_IN_ENABLE, S_IN_ENABLE,
               SIZE_L_IN, F_IN, I_IN, A_IN, S_IN,
        input  READY, F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_OUT_ENABLE_REQ,
               S_OUT_ENABLE, S_OUT
    );

    modport slave (
        input  START, F_IN_ENABLE, I_IN_ENABLE, A_IN_ENABLE, S_IN_ENABLE,
               SIZE_L_IN, F_IN, I_IN, A_IN, S_IN,
        output READY, F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_OUT_ENABLE_REQ,
               S_OUT_ENABLE, S_OUT
    );

endinterface

// File: rtl/accelerator_state_vector_update_fixed_multiplier.sv
// Signed fixed-point multiply: full product, arithmetic Q shift, saturate back to DATA_SIZE.
module accelerator_fixed_multiplier
    import accelerator_state_vector_update_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic signed [DATA_SIZE-1:0] a_i,
    input  logic signed [DATA_SIZE-1:0] b_i,
    output logic signed [DATA_SIZE-1:0] product_o
);

    logic signed [2*DATA_SIZE-1:0] full_w;
    logic signed [2*DATA_SIZE-1:0] shifted_w;
    logic signed [MAX_DATA_SIZE-1:0] sat_w;

    assign full_w    = a_i * b_i;
    // Arithmetic shift floors toward minus infinity, which is the intended rounding.
    assign shifted_w = full_w >>> FRACTION_SIZE;
    assign sat_w     = saturate(SAT_WIDTH'(shifted_w), DATA_SIZE);
    assign product_o = sat_w[DATA_SIZE-1:0];

endmodule

// File: rtl/accelerator_state_vector_update.sv
// LSTM cell-state update s = f*s_prev + i*a, one element at a time over a vector of length L.
module accelerator_state_vector_update
    import accelerator_state_vector_update_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32,
    parameter int CONTROL_SIZE  = 4
) (
    input logic                              CLK,
    input logic                              RST,
    accelerator_state_vector_update_if.slave bus
);

    if (FRACTION_SIZE >= DATA_SIZE || DATA_SIZE > MAX_DATA_SIZE || CONTROL_SIZE < 1) begin : g_bad_params
        $error("accelerator_state_vector_update: illegal parameter combination");
    end

    localparam logic [DATA_SIZE-1:0] ZERO_D = ZERO_DATA[DATA_SIZE-1:0];
    localparam logic [DATA_SIZE-1:0] ONE_D  = ONE_DATA[DATA_SIZE-1:0];

    state_t                      state_q, state_d;
    operand_flags_t              flags_q, flags_d;
    logic        [DATA_SIZE-1:0] size_l_q, size_l_d;
    logic        [DATA_SIZE-1:0] index_q, index_d;
    logic signed [DATA_SIZE-1:0] f_q, f_d, i_q, i_d, a_q, a_d, s_q, s_d;
    logic signed [DATA_SIZE-1:0] pf_q, pf_d, pi_q, pi_d;
    logic signed [DATA_SIZE-1:0] s_out_q, s_out_d;
    logic                        ready_q, ready_d;
    logic                        req_q, req_d;
    logic                        s_out_en_q, s_out_en_d;

    logic signed [DATA_SIZE-1:0]     pf_w, pi_w;
    logic signed [DATA_SIZE:0]       sum_w;
    logic signed [MAX_DATA_SIZE-1:0] sum_sat_w;

    accelerator_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul_forget (
        .a_i      (f_q),
        .b_i      (s_q),
        .product_o(pf_w)
    );

    accelerator_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul_input (
        .a_i      (i_q),
        .b_i      (a_q),
        .product_o(pi_w)
    );

    // One guard bit is enough for the sum of two saturated DATA_SIZE values.
    assign sum_w     = {pf_q[DATA_SIZE-1], pf_q} + {pi_q[DATA_SIZE-1], pi_q};
    assign sum_sat_w = saturate(SAT_WIDTH'(sum_w), DATA_SIZE);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        flags_d    = flags_q;
        size_l_d   = size_l_q;
        index_d    = index_q;
        f_d        = f_q;
        i_d        = i_q;
        a_d        = a_q;
        s_d        = s_q;
        pf_d       = pf_q;
        pi_d       = pi_q;
        s_out_d    = s_out_q;
        ready_d    = 1'b0;
        req_d      = 1'b0;
        s_out_en_d = 1'b0;

        unique case (state_q)
            STARTER_STATE: begin
                if (bus.START) begin
                    size_l_d = bus.SIZE_L_IN;
                    index_d  = ZERO_D;
                    if (bus.SIZE_L_IN == ZERO_D) begin
                        ready_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        state_d = INPUT_STATE;
                    end
                end
            end
            INPUT_STATE: begin
                // First capture wins: an operand already held ignores later enables.
                if (bus.F_IN_ENABLE && !flags_q.f) begin f_d = bus.F_IN; flags_d.f = 1'b1; end
                if (bus.I_IN_ENABLE && !flags_q.i) begin i_d = bus.I_IN; flags_d.i = 1'b1; end
                if (bus.A_IN_ENABLE && !flags_q.a) begin a_d = bus.A_IN; flags_d.a = 1'b1; end
                if (bus.S_IN_ENABLE && !flags_q.s) begin s_d = bus.S_IN; flags_d.s = 1'b1; end
                if (&flags_d) begin
                    state_d = MULTIPLY_STATE;
                end
            end
            MULTIPLY_STATE: begin
                pf_d    = pf_w;
                pi_d    = pi_w;
                state_d = ADD_STATE;
            end
            ADD_STATE: begin
                s_out_d    = sum_sat_w[DATA_SIZE-1:0];
                s_out_en_d = 1'b1;
                flags_d    = '0;
                if (index_q == size_l_q - ONE_D) begin
                    ready_d = 1'b1;
                    state_d = STARTER_STATE;
                end else begin
                    index_d = index_q + ONE_D;
                    req_d   = 1'b1;
                    state_d = INPUT_STATE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= STARTER_STATE;
            flags_q    <= '0;
            size_l_q   <= ZERO_D;
            index_q    <= ZERO_D;
            f_q        <= ZERO_D;
            i_q        <= ZERO_D;
            a_q        <= ZERO_D;
            s_q        <= ZERO_D;
            pf_q       <= ZERO_D;
            pi_q       <= ZERO_D;
            s_out_q    <= ZERO_D;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            s_out_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            size_l_q   <= size_l_d;
            index_q    <= index_d;
            f_q        <= f_d;
            i_q        <= i_d;
            a_q        <= a_d;
            s_q        <= s_d;
            pf_q       <= pf_d;
            pi_q       <= pi_d;
            s_out_q    <= s_out_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            s_out_en_q <= s_out_en_d;
        end
    end

    assign bus.READY            = ready_q;
    assign bus.F_OUT_ENABLE     = req_q;
    assign bus.I_OUT_ENABLE     = req_q;
    assign bus.A_OUT_ENABLE     = req_q;
    assign bus.S_OUT_ENABLE_REQ = req_q;
    assign bus.S_OUT_ENABLE     = s_out_en_q;
    assign bus.S_OUT            = s_out_q;

endmodule

// File: tb/tb_accelerator_state_vector_update.sv
// Directed and randomized bench for the cell-state update engine, Q16.16 on 32-bit data.
module tb_accelerator_state_vector_update;

    localparam int DS = 32;
    localparam int FS = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    accelerator_state_vector_update_if #(.DATA_SIZE(DS)) bus ();

    accelerator_state_vector_update #(
        .DATA_SIZE    (DS),
        .FRACTION_SIZE(FS),
        .CONTROL_SIZE (4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int n_ready = 0;
    int n_sout  = 0;
    int n_req   = 0;

    always @(negedge CLK) begin
        if (bus.READY)        n_ready++;
        if (bus.S_OUT_ENABLE) n_sout++;
        if (bus.F_OUT_ENABLE) n_req++;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Real-valued meaning: s = f*s_prev + i*a, each product floored to Q16 and clamped to 32 bits.
    function automatic logic [31:0] model(input logic [31:0] f, input logic [31:0] s,
                                          input logic [31:0] i, input logic [31:0] a);
        longint pf, pi, sum;
        pf  = sat32((longint'(signed'(f)) * longint'(signed'(s))) >>> FS);
        pi  = sat32((longint'(signed'(i)) * longint'(signed'(a))) >>> FS);
        sum = sat32(pf + pi);
        return sum[31:0];
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        if ($urandom_range(0, 2) == 0) begin
            v = $urandom;
        end else begin
            v = $urandom_range(0, 32'h0004_0000);
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        bus.START       = 1'b0;
        bus.F_IN_ENABLE = 1'b0;
        bus.I_IN_ENABLE = 1'b0;
        bus.A_IN_ENABLE = 1'b0;
        bus.S_IN_ENABLE = 1'b0;
        bus.SIZE_L_IN   = '0;
        bus.F_IN        = '0;
        bus.I_IN        = '0;
        bus.A_IN        = '0;
        bus.S_IN        = '0;
    endtask

    task automatic start_vector(input logic [31:0] len);
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.SIZE_L_IN = len;
        @(negedge CLK);
        bus.START     = 1'b0;
    endtask

    task automatic drive_all(input logic [31:0] f, input logic [31:0] s,
                             input logic [31:0] i, input logic [31:0] a);
        bus.F_IN = f; bus.S_IN = s; bus.I_IN = i; bus.A_IN = a;
        bus.F_IN_ENABLE = 1'b1; bus.S_IN_ENABLE = 1'b1;
        bus.I_IN_ENABLE = 1'b1; bus.A_IN_ENABLE = 1'b1;
        @(negedge CLK);
        bus.F_IN_ENABLE = 1'b0; bus.S_IN_ENABLE = 1'b0;
        bus.I_IN_ENABLE = 1'b0; bus.A_IN_ENABLE = 1'b0;
    endtask

    task automatic wait_sout(input string tag);
        for (int k = 0; k < 10; k++) begin
            if (bus.S_OUT_ENABLE) break;
            @(negedge CLK);
        end
        check({tag, "_sout_en_seen"}, 64'(bus.S_OUT_ENABLE), 64'd1);
    endtask

    // L=1 vector with all operands in one cycle and exact latency checks.
    task automatic run_single(input string tag, input logic [31:0] f, input logic [31:0] s,
                              input logic [31:0] i, input logic [31:0] a);
        start_vector(1);
        check({tag, "_req_f"}, 64'(bus.F_OUT_ENABLE), 64'd1);
        check({tag, "_req_s"}, 64'(bus.S_OUT_ENABLE_REQ), 64'd1);
        drive_all(f, s, i, a);
        check({tag, "_lat1"}, 64'(bus.S_OUT_ENABLE), 64'd0);
        @(negedge CLK);
        check({tag, "_lat2"}, 64'(bus.S_OUT_ENABLE), 64'd0);
        @(negedge CLK);
        check({tag, "_sout_en"}, 64'(bus.S_OUT_ENABLE), 64'd1);
        check({tag, "_ready"}, 64'(bus.READY), 64'd1);
        check({tag, "_sout"}, 64'(bus.S_OUT), 64'(model(f, s, i, a)));
        @(negedge CLK);
        check({tag, "_pulse_end"}, 64'({bus.READY, bus.S_OUT_ENABLE}), 64'd0);
        check({tag, "_hold"}, 64'(bus.S_OUT), 64'(model(f, s, i, a)));
    endtask

    initial begin
        int base_ready, base_sout, base_req;
        logic [31:0] f, s, i, a, f_dup;

        idle_inputs();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_ready", 64'(bus.READY), 64'd0);
        check("rst_sout", 64'(bus.S_OUT), 64'd0);
        check("rst_sout_en", 64'(bus.S_OUT_ENABLE), 64'd0);
        check("rst_reqs", 64'({bus.F_OUT_ENABLE, bus.I_OUT_ENABLE, bus.A_OUT_ENABLE, bus.S_OUT_ENABLE_REQ}), 64'd0);
        RST = 1'b1;

        run_single("half", 32'h0000_8000, 32'h0002_0000, 32'h0000_4000, 32'h0004_0000);
        check("half_const", 64'(bus.S_OUT), 64'h0002_0000);
        run_single("sat", 32'h0001_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'h0001_0000);
        check("sat_const", 64'(bus.S_OUT), 64'h7FFF_FFFF);
        run_single("neg", 32'h0001_0000, 32'hFFFE_8000, 32'h0000_0000, 32'h1234_5678);
        check("neg_const", 64'(bus.S_OUT), 64'hFFFE_8000);
        run_single("negsat", 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);

        for (int r = 0; r < 8; r++) begin
            run_single($sformatf("rnd%0d", r), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end

        // L=3 with staggered operands and a late duplicate forget value.
        base_ready = n_ready; base_sout = n_sout; base_req = n_req;
        start_vector(3);
        check("stag_req0", 64'(bus.F_OUT_ENABLE), 64'd1);
        for (int e = 0; e < 3; e++) begin
            f = rnd_op(); s = rnd_op(); i = rnd_op(); a = rnd_op();
            f_dup = ~f;
            bus.F_IN = f; bus.F_IN_ENABLE = 1'b1;
            @(negedge CLK);
            bus.F_IN = f_dup; bus.I_IN = i; bus.I_IN_ENABLE = 1'b1;
            @(negedge CLK);
            bus.F_IN_ENABLE = 1'b0; bus.I_IN_ENABLE = 1'b0;
            bus.A_IN = a; bus.A_IN_ENABLE = 1'b1;
            @(negedge CLK);
            bus.A_IN_ENABLE = 1'b0;
            bus.S_IN = s; bus.S_IN_ENABLE = 1'b1;
            @(negedge CLK);
            bus.S_IN_ENABLE = 1'b0;
            wait_sout($sformatf("stag%0d", e));
            check($sformatf("stag%0d_sout", e), 64'(bus.S_OUT), 64'(model(f, s, i, a)));
            check($sformatf("stag%0d_ready", e), 64'(bus.READY), (e == 2) ? 64'd1 : 64'd0);
        end
        repeat (4) @(negedge CLK);
        check("stag_n_sout", 64'(n_sout - base_sout), 64'd3);
        check("stag_n_req", 64'(n_req - base_req), 64'd3);
        check("stag_n_ready", 64'(n_ready - base_ready), 64'd1);

        // Zero-length vector.
        base_ready = n_ready; base_sout = n_sout; base_req = n_req;
        start_vector(0);
        check("zero_ready", 64'(bus.READY), 64'd1);
        check("zero_req", 64'(bus.F_OUT_ENABLE), 64'd0);
        repeat (4) @(negedge CLK);
        check("zero_n_sout", 64'(n_sout - base_sout), 64'd0);
        check("zero_n_req", 64'(n_req - base_req), 64'd0);
        check("zero_n_ready", 64'(n_ready - base_ready), 64'd1);

        // Reset while element 1 of 3 is being multiplied.
        base_ready = n_ready;
        start_vector(3);
        f = rnd_op(); s = rnd_op(); i = rnd_op(); a = rnd_op();
        drive_all(f, s, i, a);
        wait_sout("abort0");
        check("abort0_sout", 64'(bus.S_OUT), 64'(model(f, s, i, a)));
        drive_all(32'h0001_0000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000);
        RST = 1'b0;
        #1;
        check("abort_sout", 64'(bus.S_OUT), 64'd0);
        check("abort_outs", 64'({bus.READY, bus.S_OUT_ENABLE, bus.F_OUT_ENABLE, bus.I_OUT_ENABLE,
                                bus.A_OUT_ENABLE, bus.S_OUT_ENABLE_REQ}), 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("abort_no_ready", 64'(n_ready - base_ready), 64'd0);
        run_single("after_rst", 32'h0000_8000, 32'h0002_0000, 32'h0000_4000, 32'h0004_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accelerator_state_vector_update.md
Name: accelerator_state_vector_update

Overview:
- Downstream consumer of the LSTM forget gate vector. Computes the cell state update s(t;l) = f(t;l)*s(t-1;l) + i(t;l)*a(t;l) for l in 0 to L-1.
- Element-serial streaming: per element it requests and captures four operands (forget, input gate, activation, previous state), then emits one state value.
- Feeds the output/hidden stage of the LSTM controller.

Parameters:
- DATA_SIZE, 64, operand/result width; signed two's-complement fixed point.
- FRACTION_SIZE, 32, number of fractional bits (Q format); must be less than DATA_SIZE.
- CONTROL_SIZE, 4, kept for interface uniformity; unused internally.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  begin a vector; sampled only in STARTER_STATE.
- READY  out  1  one-cycle pulse: vector complete.
- F_IN_ENABLE  in  1  F_IN valid this cycle (forget gate element l).
- I_IN_ENABLE  in  1  I_IN valid (input gate element l).
- A_IN_ENABLE  in  1  A_IN valid (activation element l).
- S_IN_ENABLE  in  1  S_IN valid (previous state element l).
- F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_OUT_ENABLE_REQ  out  1 each  one-cycle request pulse for the next element of each stream.
- S_OUT_ENABLE  out  1  S_OUT valid, one-cycle pulse per element.
- SIZE_L_IN  in  DATA_SIZE  vector length L; sampled at START.
- F_IN, I_IN, A_IN, S_IN  in  DATA_SIZE each  operand data.
- S_OUT  out  DATA_SIZE  updated state element s(t;l).

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, index_l=0, operand flags cleared, state=STARTER_STATE. Reset mid-vector aborts silently; no READY is issued.
- STARTER_STATE: READY is 0. On START=1, latch SIZE_L_IN and set index_l=0.
  - If the latched L=0: pulse READY on the next edge and stay in STARTER_STATE.
  - Otherwise: pulse all four request outputs for one cycle and go to INPUT_STATE.
- INPUT_STATE: each *_IN_ENABLE=1 captures its data and sets its flag.
  - An enable whose flag is already set is ignored; first capture wins.
  - Any subset of enables may arrive in the same cycle.
  - When all four flags are set, including on the capturing edge itself, go to MULTIPLY_STATE.
- MULTIPLY_STATE:
  - pf = f*s and pi = i*a, full 2*DATA_SIZE-bit signed products.
  - Each product is arithmetically right-shifted by FRACTION_SIZE (truncation toward minus infinity).
  - Registered; go to ADD_STATE.
- ADD_STATE:
  - sum = pf + pi computed at DATA_SIZE+1 bits, saturated to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - Shifted products that overflow DATA_SIZE saturate the same way before the add.
  - Register S_OUT=sum, pulse S_OUT_ENABLE, clear flags.
  - If index_l = L-1: pulse READY on the same edge and go to STARTER_STATE.
  - Otherwise: index_l+1, pulse all request outputs on the same edge, and go to INPUT_STATE.
- Latency: S_OUT_ENABLE rises 2 edges after the edge capturing the last operand. Minimum throughput is 3 cycles per element.
- S_OUT holds its value between pulses. All *_ENABLE and READY outputs are single-cycle pulses.
- START outside STARTER_STATE is ignored. Operand enables outside INPUT_STATE are ignored.
- index_l is DATA_SIZE wide and compared against L-1; no wrap within a legal vector.

Decomposition:
- Shared package: state encoding (STARTER_STATE, INPUT_STATE, MULTIPLY_STATE, ADD_STATE as a 2-bit enum), ZERO_DATA/ONE_DATA constants, and a saturate-to-DATA_SIZE function.
- One natural sub-module: accelerator_fixed_multiplier, a signed DATA_SIZE×DATA_SIZE product with Q shift and saturation. Instantiate it twice, for pf and pi.

Test Plan (DATA_SIZE=32, FRACTION_SIZE=16):
- L=1, f=0x00008000 (0.5), s=0x00020000 (2.0), i=0x00004000 (0.25), a=0x00040000 (4.0), all enables in one cycle -> S_OUT=0x00020000; S_OUT_ENABLE and READY pulse together 2 edges after capture.
- L=1, f=0x00010000, s=0x7FFFFFFF, i=0x00010000, a=0x00010000 -> S_OUT=0x7FFFFFFF (saturation).
- L=1, f=0x00010000, s=0xFFFE8000 (-1.5), i=0, a=0x12345678 -> S_OUT=0xFFFE8000 (signed path).
- L=3, operands staggered over several cycles, with a duplicate F_IN_ENABLE carrying a different value after the first:
  - first value is used;
  - exactly 3 S_OUT_ENABLE pulses and 3 request pulses (at START and after elements 0 and 1);
  - exactly 1 READY.
- SIZE_L_IN=0 with START -> READY pulse on the next edge; no request or S_OUT_ENABLE pulses.
- RST low while in MULTIPLY_STATE of element 1 of 3 -> all outputs 0 immediately, no READY; a new START then runs normally from element 0.
